// File: rtl/mux_sel_sequencer.sv
// Front-end for a 5-bit 2:1 multiplexer: captures operands A and B from a shared bus
// and alternates the select every DWELL cycles while enabled and both operands are loaded.
module mux_sel_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] data_in,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] a,
    output logic [4:0] b,
    output logic       sel,
    output logic       valid,
    output logic       toggle
);

    localparam int unsigned DATA_W = 5;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL_A = 2'd1,
        SEL_B = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sel_nxt;
    logic               toggle_nxt;
    logic               have_a;
    logic               have_b;
    logic               have_a_nxt;
    logic               have_b_nxt;
    logic               valid_nxt;
    logic [DATA_W-1:0]  a_nxt;
    logic [DATA_W-1:0]  b_nxt;

    // Operand capture; valid tracks the post-edge flags so it appears with the completing load.
    always_comb begin
        a_nxt      = a;
        b_nxt      = b;
        have_a_nxt = have_a;
        have_b_nxt = have_b;
        if (clear) begin
            a_nxt      = '0;
            b_nxt      = '0;
            have_a_nxt = 1'b0;
            have_b_nxt = 1'b0;
        end else begin
            if (load_a) begin
                a_nxt      = data_in;
                have_a_nxt = 1'b1;
            end
            if (load_b) begin
                b_nxt      = data_in;
                have_b_nxt = 1'b1;
            end
        end
        valid_nxt = have_a_nxt & have_b_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sel_nxt    = sel;
        toggle_nxt = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = 1'b0;
                cnt_nxt = '0;
                if (enable && valid) begin
                    state_nxt = SEL_A;
                end
            end
            SEL_A, SEL_B: begin
                // Dropping enable wins over a terminal count: exit quietly with sel back at A.
                if (!enable) begin
                    state_nxt = IDLE;
                    sel_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else if (cnt == TERM) begin
                    cnt_nxt    = '0;
                    toggle_nxt = 1'b1;
                    if (state == SEL_A) begin
                        state_nxt = SEL_B;
                        sel_nxt   = 1'b1;
                    end else begin
                        state_nxt = SEL_A;
                        sel_nxt   = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
        if (clear) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            sel_nxt    = 1'b0;
            toggle_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= 1'b0;
            toggle <= 1'b0;
            a      <= '0;
            b      <= '0;
            have_a <= 1'b0;
            have_b <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel    <= sel_nxt;
            toggle <= toggle_nxt;
            a      <= a_nxt;
            b      <= b_nxt;
            have_a <= have_a_nxt;
            have_b <= have_b_nxt;
            valid  <= valid_nxt;
        end
    end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Sequential front-end for the 5-bit 2:1 multiplexer stage. Captures two 5-bit operands from a shared input bus and drives the multiplexer's `a`, `b` and `sel` inputs, alternating `sel` every `DWELL` cycles so both operands are time-multiplexed onto the multiplexer output, for example for a scanned display. All outputs are registered and connect directly to the multiplexer inputs.

## Interface

Parameters:

- `DWELL`, default 4: cycles each source stays selected. Legal range 1..255.

Ports:

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_in`  in  5  shared operand bus.
- `load_a`  in  1  capture `data_in` into operand A on this edge.
- `load_b`  in  1  capture `data_in` into operand B on this edge.
- `clear`  in  1  synchronous clear of operands, valid flags and FSM.
- `enable`  in  1  level; permits alternation when high.
- `a`  out  5  operand A to the multiplexer.
- `b`  out  5  operand B to the multiplexer.
- `sel`  out  1  multiplexer select: 0 selects `a`, 1 selects `b`.
- `valid`  out  1  high once both A and B have been loaded since reset or `clear`.
- `toggle`  out  1  one-cycle pulse in the cycle `sel` has just changed.

## Operation

- Reset (`rst_n`=0, asynchronous):
  - `a`=0, `b`=0, `sel`=0, `valid`=0, `toggle`=0.
  - Internal flags `have_a`=0, `have_b`=0; dwell counter `cnt`=0; FSM in IDLE.
- Operand capture:
  - `load_a` high sets `a`<=`data_in` and `have_a`<=1.
  - `load_b` high sets `b`<=`data_in` and `have_b`<=1.
  - Both high on the same edge: both registers take the same `data_in`.
  - Loads are accepted in every FSM state and never disturb `cnt`, `sel` or the FSM.
- `valid` = `have_a` & `have_b`, registered. It becomes visible the cycle after the completing load.
- `clear` has the highest synchronous priority and overrides loads and `enable` on the same edge:
  - `a`, `b`, `have_a`, `have_b`, `valid`, `cnt` and `sel` go to 0.
  - FSM returns to IDLE and `toggle`=0.
- FSM states:
  - IDLE: `sel`=0, `cnt`=0. Goes to SEL_A when `enable` and `valid` are both high.
  - SEL_A: `sel`=0. `cnt` increments each cycle. When `cnt`==`DWELL`-1: `cnt`<=0, `sel`<=1, go to SEL_B, `toggle`<=1.
  - SEL_B: same as SEL_A with `sel`=1. On terminal count: `sel`<=0, go to SEL_A, `toggle`<=1.
  - From SEL_A or SEL_B: `enable`=0 returns to IDLE on the next edge with `sel`<=0 and `cnt`<=0. `toggle` does not pulse on this exit.
  - `valid` cannot drop except through `clear` or reset, and both of those force IDLE.
- `DWELL`=1: `sel` toggles every cycle while running and `toggle` stays high continuously.
- Counter width is 8 bits and `cnt` never exceeds `DWELL`-1.

## Timing

- Load latency: `load_a` sampled at edge k gives the new value on `a` after edge k. The multiplexer output follows combinationally in the same cycle.
- Start latency:
  - `enable`, with `valid` already high, sampled at edge k: FSM is in SEL_A after edge k.
  - `sel` stays 0 for `DWELL` cycles.
  - `sel`=1 and `toggle`=1 after edge k+`DWELL`.
- Period: a full A→B→A cycle is 2·`DWELL` clocks. `toggle` is high exactly one cycle per `sel` change.
- `enable` dropping at edge k: `sel`=0 after edge k, even if that edge was a terminal count.
- Same-edge `enable` and completing load: the FSM waits in IDLE because `valid` is still 0. SEL_A is entered one edge later.
- `rst_n` asserted mid-operation: all outputs reach their reset values immediately, without waiting for a clock edge. Deassertion is synchronized externally.

## Test plan

- Reset then load: reset; `data_in`=5'h0A with `load_a`; `data_in`=5'h15 with `load_b` -> `a`=0x0A, `b`=0x15, `valid`=1 one cycle after the second load, `sel`=0.
- Alternation, `DWELL`=4: `enable`=1 after `valid` -> `sel` goes 0,0,0,0,1,1,1,1,0…; `toggle` pulses on the first cycle of each new `sel` value.
- Enable before valid: `enable`=1 with only A loaded -> `sel` stays 0 and the FSM stays IDLE; `load_b` -> alternation starts one edge after `valid` rises.
- Simultaneous events:
  - `load_a` and `load_b` together with `data_in`=5'h1F -> `a`=`b`=0x1F.
  - `load_a` with `clear` on the same edge -> `a`=0, `valid`=0.
  - `load_b` mid-SEL_B -> `b` updates and the dwell timing is unchanged.
- `DWELL`=1 -> `sel` toggles every cycle and `toggle` stays high; dropping `enable` -> `sel`=0 next cycle and `toggle`=0.
- Asynchronous reset mid-SEL_B with `sel`=1 -> `sel`, `a`, `b` and `valid` read 0 before the next clock edge; after release the FSM idles until operands are reloaded.
